// File: rtl/ctrl_decode_stage_pkg.sv
// Shared types for the control decode stage.
//   opcode_e      : 3-bit opcode encoding (ADD..BEQ)
//   ctrl_bundle_t : packed control bundle, MSB first:
//                   branch mem_to_reg mem_write alu_src reg_write special mem_read sign_extend
//   state_e       : RUN / WAIT sequencing state
package ctrl_decode_stage_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_AND   = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_MOVE  = 3'd4,
    OP_RTL   = 3'd5,
    OP_XOR   = 3'd6,
    OP_BEQ   = 3'd7
  } opcode_e;

  typedef struct packed {
    logic branch;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic special;
    logic mem_read;
    logic sign_extend;
  } ctrl_bundle_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int CNT_W = 4;

  // Loads and stores are the only ops that require a post-access bubble.
  function automatic logic is_mem_op(opcode_e op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/ctrl_decode_stage_lut.sv
// Combinational opcode -> control bundle table.
// Ports:
//   op     : in  3-bit opcode
//   bundle : out decoded control bundle
module ctrl_decode_lut
  import ctrl_decode_stage_pkg::*;
(
  input  logic [2:0]   op,
  output ctrl_bundle_t bundle
);

  always_comb begin
    bundle = '0;
    unique case (opcode_e'(op))
      OP_ADD:   bundle = ctrl_bundle_t'(8'b0000_1000);
      OP_AND:   bundle = ctrl_bundle_t'(8'b0000_1000);
      OP_LOAD:  bundle = ctrl_bundle_t'(8'b0101_1110);
      OP_STORE: bundle = ctrl_bundle_t'(8'b0011_0110);
      OP_MOVE:  bundle = ctrl_bundle_t'(8'b0001_1101);
      OP_RTL:   bundle = ctrl_bundle_t'(8'b0000_1000);
      OP_XOR:   bundle = ctrl_bundle_t'(8'b0000_1000);
      OP_BEQ:   bundle = ctrl_bundle_t'(8'b1001_0101);
      default:  bundle = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode stage: accepts opcodes with a valid/ready handshake, registers the
// decoded control bundle, and inserts WAIT_CYCLES bubbles after a memory op
// leaves the stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | normal flow, in_ready follows the output skid condition
//   ST_WAIT | post-memory bubble, counter runs down to 0, in_ready = 0
//
// Ports:
//   Clk, Reset              : clock, synchronous active-high reset
//   in_valid/in_ready/instr : upstream handshake and opcode
//   flush                   : squash held and incoming instruction
//   out_valid/out_ready     : downstream handshake
//   Branch..SignExtend      : registered control bits (0 when !out_valid)
//   ALUOp                   : registered ALU op, zero-extended instr[2:0]
//   illegal_op              : sticky, an opcode >= 8 was accepted
//   busy                    : high while in ST_WAIT
module ctrl_decode_stage
  import ctrl_decode_stage_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int ALUOPW      = 3,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPW-1:0]    instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              Branch,
  output logic              MemtoReg,
  output logic              MemWrite,
  output logic              ALUSrc,
  output logic              RegWrite,
  output logic              Special,
  output logic              MemRead,
  output logic              SignExtend,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              illegal_op,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
  // One extra bit so the compare against 8 stays meaningful when OPW == 3.
  localparam logic [OPW:0] OP_LIMIT = (OPW + 1)'(8);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  ctrl_bundle_t       bundle_q, bundle_d;
  logic [ALUOPW-1:0]  aluop_q, aluop_d;
  logic               mem_q, mem_d;
  logic               illegal_q, illegal_d;

  ctrl_bundle_t       lut_bundle;
  logic               legal;
  logic               xfer_in;
  logic               xfer_out;

  ctrl_decode_lut u_lut (
    .op     (instr[2:0]),
    .bundle (lut_bundle)
  );

  assign legal    = ({1'b0, instr} < OP_LIMIT);
  assign in_ready = (!valid_q || out_ready) && (state_q == ST_RUN) && !Reset;
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = valid_q && out_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    bundle_d  = bundle_q;
    aluop_d   = aluop_q;
    mem_d     = mem_q;
    // An illegal op is flagged even if it arrives in a flush cycle.
    illegal_d = illegal_q | (xfer_in & ~legal);

    if (flush) begin
      valid_d = 1'b0;
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (xfer_out && mem_q && (WAIT_CYCLES != 0)) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = ST_RUN;
      endcase

      // in_ready guarantees the held slot is free or draining when xfer_in.
      if (xfer_in && legal) begin
        valid_d  = 1'b1;
        bundle_d = lut_bundle;
        aluop_d  = ALUOPW'(instr[2:0]);
        mem_d    = is_mem_op(opcode_e'(instr[2:0]));
      end else if (xfer_out) begin
        valid_d = 1'b0;
      end
    end

    // Empty slot always presents a NOP.
    if (!valid_d) begin
      bundle_d = '0;
      aluop_d  = '0;
      mem_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      bundle_q  <= '0;
      aluop_q   <= '0;
      mem_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      bundle_q  <= bundle_d;
      aluop_q   <= aluop_d;
      mem_q     <= mem_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid  = valid_q;
  assign Branch     = bundle_q.branch;
  assign MemtoReg   = bundle_q.mem_to_reg;
  assign MemWrite   = bundle_q.mem_write;
  assign ALUSrc     = bundle_q.alu_src;
  assign RegWrite   = bundle_q.reg_write;
  assign Special    = bundle_q.special;
  assign MemRead    = bundle_q.mem_read;
  assign SignExtend = bundle_q.sign_extend;
  assign ALUOp      = aluop_q;
  assign illegal_op = illegal_q;
  assign busy       = (state_q == ST_WAIT);

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 Parameters SHALL be: OPW, default 3, opcode width (>=3); ALUOPW, default 3, ALU op width (>=3); WAIT_CYCLES, default 1, post-memory-op bubble count (0..15).
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-004 in_valid  input  1  opcode valid; in_ready  output  1  stage can accept.
REQ-005 instr  input  OPW  opcode of the offered instruction.
REQ-006 flush  input  1  squash held and incoming instructions (taken branch).
REQ-007 out_valid  output  1  control bundle valid; out_ready  input  1  downstream accepts.
REQ-008 Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Special, MemRead, SignExtend  output  1 each  registered control bits.
REQ-009 ALUOp  output  ALUOPW  registered ALU operation, zero-extended from instr[2:0].
REQ-010 illegal_op  output  1  sticky: an opcode >= 8 was accepted.
REQ-011 busy  output  1  high while in WAIT state.

Function
REQ-012 Decode (opcode: Branch MemtoReg MemWrite ALUSrc RegWrite Special MemRead SignExtend) SHALL be: 0 add 00001000; 1 and 00001000; 2 load 01011110; 3 store 00110110; 4 move 00011101; 5 rtl 00001000; 6 xor 00001000; 7 beq 10010101.
REQ-013 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-014 in_ready SHALL equal (!out_valid || out_ready) && state==RUN && !Reset, combinationally.
REQ-015 A legal accepted opcode SHALL appear on the outputs with out_valid=1 on the next cycle (latency 1); back-to-back acceptance SHALL sustain one instruction per cycle.
REQ-016 Outputs SHALL hold stable while out_valid && !out_ready.
REQ-017 On transfer out without a same-cycle transfer in, out_valid SHALL go 0 next cycle.
REQ-018 An accepted opcode >= 8 SHALL not set out_valid, SHALL set illegal_op next cycle, and illegal_op SHALL stay 1 until Reset.
REQ-019 FSM states SHALL be RUN and WAIT; RUN->WAIT when a load or store transfers out and WAIT_CYCLES>0; counter loads WAIT_CYCLES-1 on entry.
REQ-020 In WAIT the counter SHALL decrement each cycle; WAIT->RUN in the cycle it reads 0; in_ready=0 throughout WAIT.
REQ-021 With WAIT_CYCLES=0 the WAIT state SHALL never be entered.
REQ-022 flush SHALL have priority: next cycle out_valid=0, state=RUN, counter=0; an instruction accepted in the flush cycle SHALL be discarded; illegal_op is unaffected by flush.
REQ-023 When out_valid=0, all control bits and ALUOp SHALL read 0 (NOP).

Reset
REQ-024 With Reset high at a clock edge: out_valid=0, all control outputs=0, ALUOp=0, illegal_op=0, busy=0, state=RUN, counter=0.
REQ-025 Reset asserted mid-WAIT or with a held instruction SHALL discard it; no output transfer occurs in the reset cycle.

Structure
REQ-026 A shared package SHALL hold the opcode enum (ADD..BEQ), the control-bundle packed struct, and the RUN/WAIT state enum.
REQ-027 The combinational opcode-to-bundle table SHALL be one sub-module, ctrl_decode_lut; ctrl_decode_stage adds handshake, FSM and registers.

Verification
REQ-028 Reset, then instr=0,2,7 on consecutive cycles with out_ready=1 (WAIT_CYCLES=0) -> bundles 00001000/000, 01011110/010, 10010101/111 on cycles 1,2,3.
REQ-029 WAIT_CYCLES=2: load accepted at cycle 0, out_ready=1 -> out at cycle 1, busy=1 and in_ready=0 cycles 2-3, in_ready=1 cycle 4.
REQ-030 out_ready=0 for 3 cycles with instr=6 held -> outputs stable 00001000/110, in_ready=0, then one transfer when out_ready=1.
REQ-031 OPW=4, instr=9 accepted -> out_valid stays 0, illegal_op=1 next cycle and persists through flush; cleared only by Reset.
REQ-032 flush during WAIT with in_valid=1 instr=1 -> next cycle state RUN, out_valid=0, busy=0, instr not delivered.
REQ-033 Reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all outputs 0.
